// File: rtl/tile_map_scheduler.sv
// Tile colour map with a shadow and an active copy. The shadow is copied to the
// active map during vertical blanking only, and the shadow can be bulk cleared.
module tile_map_scheduler #(
    parameter int          NTILES    = 192,
    parameter int          VLINES    = 480,
    parameter logic [11:0] CLR_COLOR = 12'h000,
    parameter int          FCW       = 16
) (
    input  logic            vgaclk,
    input  logic            rst,
    input  logic [9:0]      vc,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [7:0]      wr_idx,
    input  logic [11:0]     wr_color,
    input  logic            commit_req,
    input  logic            clr_req,
    output logic            busy,
    output logic            commit_done,
    output logic            wr_err,
    output logic [FCW-1:0]  frame_count,
    output logic [11:0]     active_map [0:NTILES-1],
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COPY  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam logic [9:0] VL      = 10'(VLINES);
    localparam logic [8:0] NT      = 9'(NTILES);
    localparam logic [7:0] LAST    = 8'(NTILES - 1);

    state_t      state;
    logic [7:0]  idx;
    logic        vblank_q;
    logic [11:0] shadow [0:NTILES-1];

    logic in_vblank;
    logic vb_edge;
    logic wr_fire;
    logic wr_in_range;

    // Write port: a transfer happens on any rising edge where wr_valid and
    // wr_ready are both high; wr_ready depends only on state, never on wr_valid.
    assign wr_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign state_dbg   = state;
    assign wr_fire     = wr_valid & wr_ready;
    assign wr_in_range = ({1'b0, wr_idx} < NT);

    // Only the 479->480 transition starts a copy, so a request made mid-vblank
    // waits a whole frame rather than racing the end of blanking.
    assign in_vblank = (vc >= VL);
    assign vb_edge   = in_vblank & ~vblank_q;

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            vblank_q    <= 1'b0;
            commit_done <= 1'b0;
            wr_err      <= 1'b0;
            frame_count <= '0;
            for (int i = 0; i < NTILES; i++) begin
                shadow[i]     <= '0;
                active_map[i] <= '0;
            end
        end else begin
            vblank_q    <= in_vblank;
            commit_done <= 1'b0;

            if (wr_fire) begin
                if (wr_in_range) begin
                    shadow[wr_idx] <= wr_color;
                end else begin
                    wr_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        idx   <= '0;
                    end else if (commit_req) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (vb_edge) begin
                        state <= COPY;
                        idx   <= '0;
                    end
                end
                COPY: begin
                    active_map[idx] <= shadow[idx];
                    if (idx == LAST) begin
                        state       <= IDLE;
                        idx         <= '0;
                        commit_done <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                CLEAR: begin
                    // Any write accepted on the clr_req cycle lands first and is overwritten here.
                    shadow[idx] <= CLR_COLOR;
                    if (idx == LAST) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Randomized bench for tile_map_scheduler: a tile-map model predicts each commit,
// and a monitor checks every commit_done against the queued expectation.
`timescale 1ns/1ps
module tb_tile_map_scheduler;

    localparam int          NT  = 192;
    localparam logic [11:0] CLR = 12'h00F;
    localparam int          FCW = 16;

    logic            vgaclk = 1'b0;
    logic            rst    = 1'b1;
    logic [9:0]      vc     = '0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [7:0]      wr_idx   = '0;
    logic [11:0]     wr_color = '0;
    logic            commit_req = 1'b0;
    logic            clr_req    = 1'b0;
    logic            busy;
    logic            commit_done;
    logic            wr_err;
    logic [FCW-1:0]  frame_count;
    logic [11:0]     active_map [0:NT-1];
    logic [1:0]      state_dbg;

    tile_map_scheduler #(
        .NTILES(NT), .VLINES(480), .CLR_COLOR(CLR), .FCW(FCW)
    ) dut (
        .vgaclk(vgaclk), .rst(rst), .vc(vc),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_color(wr_color),
        .commit_req(commit_req), .clr_req(clr_req), .busy(busy),
        .commit_done(commit_done), .wr_err(wr_err), .frame_count(frame_count),
        .active_map(active_map), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 vgaclk = ~vgaclk;

    longint cyc = 0;
    always @(posedge vgaclk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // reference model
    logic [11:0]    m_shadow [0:NT-1];
    logic [11:0]    m_active [0:NT-1];
    logic [FCW-1:0] m_fc;
    logic           m_err;

    // scoreboard
    logic [FCW-1:0]     exp_q[$];
    longint             exp_cyc_q[$];
    logic [NT*12-1:0]   exp_map_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_map(input string name);
        int bad = -1;
        for (int i = 0; i < NT; i++)
            if (bad < 0 && active_map[i] !== m_active[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s idx=%0d actual=%0h required=%0h", name, bad, active_map[bad], m_active[bad]);
        end
    endtask

    task automatic check_packed(input string name, input logic [NT*12-1:0] em);
        int bad = -1;
        for (int i = 0; i < NT; i++)
            if (bad < 0 && active_map[i] !== em[i*12 +: 12]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s idx=%0d actual=%0h required=%0h", name, bad, active_map[bad], em[bad*12 +: 12]);
        end
    endtask

    function automatic logic [NT*12-1:0] pack_shadow();
        logic [NT*12-1:0] v;
        for (int i = 0; i < NT; i++) v[i*12 +: 12] = m_shadow[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_fc  = '0;
        m_err = 1'b0;
    endtask

    // monitor
    logic [FCW-1:0]   mon_fc;
    longint           mon_cyc;
    logic [NT*12-1:0] mon_map;

    always @(negedge vgaclk) begin
        if (!rst && commit_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_commit_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                mon_fc  = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                mon_map = exp_map_q.pop_front();
                check("commit_done_cycle", cyc, mon_cyc);
                check("commit_frame_count", frame_count, mon_fc);
                check("commit_wr_ready", wr_ready, 1);
                check_packed("commit_active_map", mon_map);
            end
        end
    end

    // drivers
    task automatic tick();
        @(posedge vgaclk);
        #1;
    endtask

    task automatic do_write(input int idx, input logic [11:0] color);
        wr_valid = 1'b1;
        wr_idx   = 8'(idx);
        wr_color = color;
        check("wr_ready_idle", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        if (idx < NT) m_shadow[idx] = color;
        else m_err = 1'b1;
        check("wr_err", wr_err, m_err);
    endtask

    task automatic do_clear(input bit with_commit, input bit with_write);
        int n;
        int widx;
        logic [11:0] wcol;
        widx = $urandom_range(0, NT - 1);
        wcol = 12'($urandom);
        clr_req    = 1'b1;
        commit_req = with_commit;
        if (with_write) begin
            wr_valid = 1'b1;
            wr_idx   = 8'(widx);
            wr_color = wcol;
        end
        tick();
        clr_req = 1'b0; commit_req = 1'b0; wr_valid = 1'b0;
        if (with_write) m_shadow[widx] = wcol;
        for (int i = 0; i < NT; i++) m_shadow[i] = CLR;
        n = 0;
        while (busy && n < 400) begin
            n++;
            if (n == 50) begin
                wr_valid = 1'b1;
                wr_idx   = 8'($urandom_range(0, NT - 1));
                wr_color = 12'($urandom);
                check("wr_ready_in_clear", wr_ready, 0);
            end
            tick();
            wr_valid = 1'b0;
        end
        check("clear_cycles", n, NT);
        check("clear_frame_count", frame_count, m_fc);
        check_map("clear_active_untouched");
    endtask

    task automatic do_commit(input bit start_vb, input int abort_at);
        int n;
        longint t0;
        vc = start_vb ? 10'($urandom_range(480, 1023)) : 10'($urandom_range(0, 479));
        tick(); tick();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check("busy_armed", busy, 1);
        repeat ($urandom_range(1, 20)) begin
            vc = start_vb ? 10'($urandom_range(480, 1023)) : 10'($urandom_range(0, 479));
            tick();
        end
        check("busy_still_armed", busy, 1);
        check_map("armed_active_untouched");
        vc = 10'($urandom_range(0, 479));
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        vc = 10'($urandom_range(480, 1023));
        t0 = cyc;
        exp_q.push_back(m_fc + 1'b1);
        exp_cyc_q.push_back(t0 + NT + 1);
        exp_map_q.push_back(pack_shadow());
        n = 0;
        while (busy && n < 400) begin
            if (n == 10) begin
                commit_req = 1'b1;
                clr_req    = 1'b1;
            end
            tick();
            commit_req = 1'b0;
            clr_req    = 1'b0;
            n++;
            if (abort_at > 0 && n == abort_at) begin
                #1 rst = 1'b1;
                #1;
                exp_q.delete(); exp_cyc_q.delete(); exp_map_q.delete();
                model_reset();
                check("rst_wr_ready", wr_ready, 1);
                check("rst_busy", busy, 0);
                check("rst_frame_count", frame_count, 0);
                check("rst_commit_done", commit_done, 0);
                check("rst_wr_err", wr_err, 0);
                check_map("rst_active_map");
                tick(); tick();
                rst = 1'b0;
                vc  = 10'($urandom_range(0, 479));
                tick();
                return;
            end
        end
        check("copy_completed", busy, 0);
        for (int i = 0; i < NT; i++) m_active[i] = m_shadow[i];
        m_fc = m_fc + 1'b1;
        check_map("after_commit_map");
        check("after_commit_wr_err", wr_err, m_err);
        vc = 10'($urandom_range(0, 479));
        tick();
    endtask

    initial begin
        int op;
        int widx;
        model_reset();
        #1;
        check("reset_wr_ready", wr_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_commit_done", commit_done, 0);
        check("reset_wr_err", wr_err, 0);
        check("reset_frame_count", frame_count, 0);
        check_map("reset_active_map");
        tick(); tick();
        rst = 1'b0;
        tick();

        vc = 10'd100;
        do_write(5, 12'hF00);
        do_commit(1'b0, 0);
        check("active5_red", active_map[5], 12'hF00);
        check("frame_count_one", frame_count, 1);

        do_write(200, 12'h0F0);
        check("wr_err_oob", wr_err, 1);
        check_map("oob_no_change");
        do_commit(1'b0, 0);

        do_commit(1'b1, 0);

        do_clear(1'b1, 1'b1);
        do_commit(1'b0, 0);
        check("active0_clr", active_map[0], CLR);
        check("active191_clr", active_map[NT-1], CLR);

        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                widx = ($urandom_range(0, 9) == 0) ? $urandom_range(NT, 255) : $urandom_range(0, NT - 1);
                do_write(widx, 12'($urandom));
            end else if (op == 6) begin
                do_clear(1'($urandom), 1'($urandom));
            end else if (op <= 8) begin
                do_commit(1'($urandom), 0);
            end else begin
                repeat ($urandom_range(1, 5)) tick();
            end
        end

        do_write($urandom_range(0, NT - 1), 12'($urandom));
        do_commit(1'b0, 101);
        do_write(7, 12'hABC);
        do_commit(1'b0, 0);
        check("post_reset_frame_count", frame_count, 1);
        check("post_reset_active7", active_map[7], 12'hABC);

        repeat (3) tick();
        check("pending_commits", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
